// File: rtl/hist_accumulator_pkg.sv
// rtl/hist_accumulator_pkg.sv - shared sizes, state encoding and saturating increment
package hist_accumulator_pkg;
   localparam int BIN_NUM   = 64;
   localparam int PIXEL_NUM = 4;
   localparam int BIN_W     = $clog2(BIN_NUM);
   localparam int PIX_W     = $clog2(PIXEL_NUM);
   localparam int ADDR_W    = $clog2(BIN_NUM * PIXEL_NUM);
   localparam int COUNT_W   = 12;
   localparam int PEAK_BIN  = 0;
   localparam int LAST_ADDR = BIN_NUM * PIXEL_NUM - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_ACCUM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (&c) ? c : c + COUNT_W'(1);
   endfunction
endpackage

// File: rtl/hist_rmw_pipe.sv
// rtl/hist_rmw_pipe.sv - two-stage read-modify-write of bin counts with write-to-read forwarding
module hist_rmw_pipe
   import hist_accumulator_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               acc_valid,
   input  logic [BIN_W-1:0]   acc_bin,
   input  logic [PIX_W-1:0]   pixel,
   input  logic [COUNT_W-1:0] counts,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   output logic               wr_en,
   output logic [ADDR_W-1:0]  wr_addr,
   output logic [COUNT_W-1:0] wr_data
);
   logic               s1_valid;
   logic [ADDR_W-1:0]  s1_addr;
   logic               fwd_valid;
   logic [ADDR_W-1:0]  fwd_addr;
   logic [COUNT_W-1:0] fwd_data;
   logic [COUNT_W-1:0] inc;

   // bin 0 holds the peak result, so hits on it never touch the SRAM
   assign rd_en   = acc_valid && (acc_bin != BIN_W'(PEAK_BIN));
   assign rd_addr = ADDR_W'(pixel) * ADDR_W'(BIN_NUM) + ADDR_W'(acc_bin);

   // the SRAM read issued alongside the previous write returns stale data
   assign inc     = (fwd_valid && (fwd_addr == s1_addr)) ? fwd_data : counts;
   assign wr_en   = s1_valid;
   assign wr_addr = s1_addr;
   assign wr_data = sat_inc(inc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_addr   <= '0;
         fwd_valid <= 1'b0;
         fwd_addr  <= '0;
         fwd_data  <= '0;
      end else begin
         s1_valid  <= rd_en;
         if (rd_en)
            s1_addr <= rd_addr;
         fwd_valid <= s1_valid;
         if (s1_valid) begin
            fwd_addr <= s1_addr;
            fwd_data <= wr_data;
         end
      end
   end
endmodule

// File: rtl/hist_accumulator.sv
// rtl/hist_accumulator.sv - histogram SRAM write side: clear, per-pixel accumulate, finish handoff
module hist_accumulator
   import hist_accumulator_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               hit_valid,
   output logic               hit_ready,
   input  logic [BIN_W-1:0]   hit_bin,
   input  logic               pixel_end,
   output logic               rEnable,
   output logic [ADDR_W-1:0]  raddr,
   input  logic [COUNT_W-1:0] counts,
   output logic               wEnable,
   output logic [ADDR_W-1:0]  waddr,
   output logic [COUNT_W-1:0] newCounts,
   output logic               histFinish
);
   state_t             state;
   logic [PIX_W-1:0]   pixel;
   logic               clr_en;
   logic [ADDR_W-1:0]  clr_addr;
   logic [ADDR_W-1:0]  raddr_hold;
   logic [ADDR_W-1:0]  waddr_hold;
   logic [COUNT_W-1:0] wdata_hold;
   logic               pipe_rd_en;
   logic [ADDR_W-1:0]  pipe_rd_addr;
   logic               pipe_wr_en;
   logic [ADDR_W-1:0]  pipe_wr_addr;
   logic [COUNT_W-1:0] pipe_wr_data;

   hist_rmw_pipe u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .acc_valid (hit_valid & hit_ready),
      .acc_bin   (hit_bin),
      .pixel     (pixel),
      .counts    (counts),
      .rd_en     (pipe_rd_en),
      .rd_addr   (pipe_rd_addr),
      .wr_en     (pipe_wr_en),
      .wr_addr   (pipe_wr_addr),
      .wr_data   (pipe_wr_data)
   );

   // clear and pipeline writes never overlap; addresses hold when idle
   assign rEnable   = pipe_rd_en;
   assign raddr     = pipe_rd_en ? pipe_rd_addr : raddr_hold;
   assign wEnable   = clr_en | pipe_wr_en;
   assign waddr     = clr_en ? clr_addr : (pipe_wr_en ? pipe_wr_addr : waddr_hold);
   assign newCounts = clr_en ? '0 : (pipe_wr_en ? pipe_wr_data : wdata_hold);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_hold <= '0;
         waddr_hold <= '0;
         wdata_hold <= '0;
      end else begin
         raddr_hold <= raddr;
         waddr_hold <= waddr;
         wdata_hold <= newCounts;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         hit_ready  <= 1'b0;
         clr_en     <= 1'b0;
         clr_addr   <= '0;
         pixel      <= '0;
         histFinish <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_CLEAR;
                  clr_en     <= 1'b1;
                  clr_addr   <= '0;
                  histFinish <= 1'b0;
               end
            end
            ST_CLEAR: begin
               if (clr_addr == ADDR_W'(LAST_ADDR)) begin
                  clr_en    <= 1'b0;
                  pixel     <= '0;
                  hit_ready <= 1'b1;
                  state     <= ST_ACCUM;
               end else begin
                  clr_addr <= clr_addr + ADDR_W'(1);
               end
            end
            ST_ACCUM: begin
               if (pixel_end) begin
                  hit_ready <= 1'b0;
                  state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // the final hit of the pixel is written during this cycle
               pixel <= pixel + PIX_W'(1);
               if (pixel == PIX_W'(PIXEL_NUM - 1)) begin
                  histFinish <= 1'b1;
                  state      <= ST_DONE;
               end else begin
                  hit_ready <= 1'b1;
                  state     <= ST_ACCUM;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
